// File: rtl/esc_bank.sv
// Multi-channel ESC PWM bank: slew-limited speed updates, command-loss watchdog,
// frame-latched pulse widths. Define PWM_STAGGER_EN to spread channel pulse phases.
module esc_bank #(
  parameter int NUM_CH    = 4,
  parameter int SPD_W     = 11,
  parameter int PERIOD_W  = 20,
  parameter int MIN_PULSE = 50000,
  parameter int SCALE     = 3,
  parameter int MAX_STEP  = 0,
  parameter int WDOG_W    = 24,
  parameter int WDOG_CYC  = 5000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*SPD_W-1:0] spd,
  input  logic                    wrt,
  input  logic                    motors_off,
  output logic [NUM_CH-1:0]       pwm,
  output logic                    wdog_trip,
  output logic                    frm_strt
);

  localparam longint PULSE_MAX = longint'(MIN_PULSE) +
                                 ((longint'(1) << SPD_W) - 1) * longint'(SCALE);

  generate
    if (PULSE_MAX >= (longint'(1) << PERIOD_W)) begin : g_cfg_err
      $fatal(1, "esc_bank: longest pulse does not fit in one frame");
    end
  endgenerate

  localparam logic [PERIOD_W-1:0] CNT_LAST = '1;
  localparam logic [PERIOD_W-1:0] MIN_P    = PERIOD_W'(MIN_PULSE);
  localparam logic [PERIOD_W-1:0] SCALE_P  = PERIOD_W'(SCALE);
  localparam logic [WDOG_W-1:0]   WDOG_LIM = WDOG_W'(WDOG_CYC);

  logic [PERIOD_W-1:0] cnt_reg;
  logic [WDOG_W-1:0]   wd_cnt_reg, wd_cnt_next;
  logic                wdog_trip_reg, wdog_trip_next;
  logic                frm_strt_reg;

  // Watchdog: any wrt restarts the count, but only an accepted wrt releases a trip.
  always_comb begin
    wd_cnt_next    = wd_cnt_reg;
    wdog_trip_next = wdog_trip_reg;
    if (WDOG_CYC == 0) begin
      wd_cnt_next    = '0;
      wdog_trip_next = 1'b0;
    end else if (wrt) begin
      wd_cnt_next = '0;
      if (!motors_off) wdog_trip_next = 1'b0;
    end else if (wd_cnt_reg != WDOG_LIM) begin
      wd_cnt_next = wd_cnt_reg + 1'b1;
      if (wd_cnt_next == WDOG_LIM) wdog_trip_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg       <= '0;
      wd_cnt_reg    <= '0;
      wdog_trip_reg <= 1'b0;
      frm_strt_reg  <= 1'b0;
    end else begin
      cnt_reg       <= cnt_reg + 1'b1;
      wd_cnt_reg    <= wd_cnt_next;
      wdog_trip_reg <= wdog_trip_next;
      frm_strt_reg  <= (cnt_reg == '0);
    end
  end

  assign wdog_trip = wdog_trip_reg;
  assign frm_strt  = frm_strt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
`ifdef PWM_STAGGER_EN
      localparam logic [PERIOD_W-1:0] PHASE_OFS = PERIOD_W'(gi * ((1 << PERIOD_W) / NUM_CH));
`else
      localparam logic [PERIOD_W-1:0] PHASE_OFS = '0;
`endif
      logic [SPD_W-1:0]    tgt, base, app_reg, app_next;
      logic [PERIOD_W-1:0] phase, plat_reg;
      logic                pwm_reg;

      assign tgt   = spd[gi*SPD_W +: SPD_W];
      // A tripped channel may not have been zeroed yet; slew always restarts from 0.
      assign base  = wdog_trip_reg ? '0 : app_reg;
      assign phase = cnt_reg - PHASE_OFS;

      always_comb begin
        app_next = app_reg;
        if (motors_off) begin
          app_next = '0;
        end else if (wrt) begin
          if (MAX_STEP == 0)
            app_next = tgt;
          else if (32'(tgt) > 32'(base) + MAX_STEP)
            app_next = SPD_W'(32'(base) + MAX_STEP);
          else if (32'(tgt) + MAX_STEP < 32'(base))
            app_next = SPD_W'(32'(base) - MAX_STEP);
          else
            app_next = tgt;
        end else if (wdog_trip_reg) begin
          app_next = '0;
        end
      end

      // Width is latched only at the end of the channel's frame, so pulses never glitch.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          app_reg  <= '0;
          plat_reg <= MIN_P;
          pwm_reg  <= 1'b0;
        end else begin
          app_reg <= app_next;
          if (phase == CNT_LAST)
            plat_reg <= MIN_P + PERIOD_W'(app_reg) * SCALE_P;
          pwm_reg <= (phase < plat_reg);
        end
      end

      assign pwm[gi] = pwm_reg;
    end
  endgenerate

endmodule

// File: tb/tb_esc_bank.sv
// Scoreboard bench for esc_bank: per-frame pulse widths checked against queued expectations,
// plus watchdog latency, slew steps, motors_off priority and asynchronous reset.
module tb_esc_bank;
  localparam int NCH  = 4;
  localparam int SW   = 8;
  localparam int PW   = 10;
  localparam int MINP = 100;
  localparam int SC   = 2;
  localparam int WD   = 5000;
  localparam int FRM  = 1 << PW;

  typedef logic [NCH-1:0][15:0] widths_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, wrt, wrt_s, motors_off;
  logic [NCH*SW-1:0] spd, spd_s;
  logic [NCH-1:0]    pwm, pwm_s;
  logic              wdog_trip, frm_strt, wdog_trip_s, frm_strt_s;

  esc_bank #(.NUM_CH(NCH), .SPD_W(SW), .PERIOD_W(PW), .MIN_PULSE(MINP), .SCALE(SC),
             .MAX_STEP(0), .WDOG_W(24), .WDOG_CYC(WD)) dut (
    .clk(clk), .rst_n(rst_n), .spd(spd), .wrt(wrt), .motors_off(motors_off),
    .pwm(pwm), .wdog_trip(wdog_trip), .frm_strt(frm_strt));

  esc_bank #(.NUM_CH(NCH), .SPD_W(SW), .PERIOD_W(PW), .MIN_PULSE(MINP), .SCALE(SC),
             .MAX_STEP(16), .WDOG_W(24), .WDOG_CYC(WD)) dut_slew (
    .clk(clk), .rst_n(rst_n), .spd(spd_s), .wrt(wrt_s), .motors_off(1'b0),
    .pwm(pwm_s), .wdog_trip(wdog_trip_s), .frm_strt(frm_strt_s));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  function automatic widths_t mk(input int a, input int b, input int c, input int d);
    widths_t w;
    w[0] = 16'(a); w[1] = 16'(b); w[2] = 16'(c); w[3] = 16'(d);
    return w;
  endfunction

  widths_t q_main[$];
  int      q_slew[$];

  // Monitor: a frame runs from one frm_strt to the next; it is checked only if an
  // expectation was queued before it began.
  logic    mon_en = 1'b0;
  bit      open_m = 0, open_s = 0;
  int      flen = 0, cnt_s = 0;
  int      cnt_m[NCH];
  widths_t e_m;
  int      e_s;

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (frm_strt) begin
        if (open_m) begin
          e_m = q_main.pop_front();
          for (int i = 0; i < NCH; i++)
            check_val($sformatf("width_ch%0d", i), cnt_m[i], e_m[i]);
          check_val("frame_len", flen, FRM);
        end
        open_m = (q_main.size() != 0);
        if (open_s) begin
          e_s = q_slew.pop_front();
          check_val("slew_width_ch0", cnt_s, e_s);
        end
        open_s = (q_slew.size() != 0);
        flen  = 0;
        cnt_s = 0;
        for (int i = 0; i < NCH; i++) cnt_m[i] = 0;
      end
      flen++;
      cnt_s += int'(pwm_s[0]);
      for (int i = 0; i < NCH; i++) cnt_m[i] += int'(pwm[i]);
    end
  end

  task automatic wait_frm(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frm_strt && n < 2 * FRM + 50);
    if (!frm_strt) check_val({tag, "_frm_timeout"}, 0, 1);
  endtask

  task automatic mid_frame(input string tag);
    wait_frm(tag);
    repeat (300) @(negedge clk);
  endtask

  task automatic drive_wrt(input int a, input int b, input int c, input int d, input logic mo);
    spd        = {8'(d), 8'(c), 8'(b), 8'(a)};
    wrt        = 1'b1;
    motors_off = mo;
    @(negedge clk);
    wrt        = 1'b0;
    motors_off = 1'b0;
  endtask

  task automatic slew_seq();
    for (int k = 1; k <= 7; k++) begin
      int app;
      mid_frame("slew");
      spd_s = {24'd0, 8'd100};
      wrt_s = 1'b1;
      @(negedge clk);
      wrt_s = 1'b0;
      app = (16 * k < 100) ? 16 * k : 100;
      q_slew.push_back(MINP + SC * app);
    end
  endtask

  initial begin
    int wd;
    rst_n = 1'b0; spd = '0; spd_s = '0; wrt = 1'b0; wrt_s = 1'b0; motors_off = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_pwm", pwm, 0);
    check_val("rst_pwm_slew", pwm_s, 0);
    check_val("rst_wdog_trip", wdog_trip, 0);
    check_val("rst_frm_strt", frm_strt, 0);
    @(negedge clk);
    q_main.push_back(mk(MINP, MINP, MINP, MINP));
    q_slew.push_back(MINP);
    mon_en = 1'b1;
    rst_n  = 1'b1;
    fork
      slew_seq();
    join_none

    // F0: speed 0 keeps the minimum pulse.
    mid_frame("f0");
    drive_wrt(0, 0, 0, 0, 1'b0);
    q_main.push_back(mk(100, 100, 100, 100));
    // F1: mid-frame write must only affect the following frame.
    mid_frame("f1");
    drive_wrt(0, 10, 100, 255, 1'b0);
    q_main.push_back(mk(100, 120, 300, 610));
    mid_frame("f2");
    drive_wrt(0, 10, 100, 255, 1'b0);
    q_main.push_back(mk(100, 120, 300, 610));
    // F3: motors_off wins over a simultaneous write.
    mid_frame("f3");
    drive_wrt(200, 200, 200, 200, 1'b1);
    q_main.push_back(mk(100, 100, 100, 100));
    // F4: motors_off released, no new write: speeds stay 0.
    mid_frame("f4");
    q_main.push_back(mk(100, 100, 100, 100));
    // F5: last write before the watchdog is allowed to expire.
    mid_frame("f5");
    drive_wrt(50, 50, 50, 50, 1'b0);
    q_main.push_back(mk(200, 200, 200, 200));
    wd = 1;
    while (!wdog_trip && wd < WD + 1000) begin
      @(negedge clk);
      wd++;
    end
    // Sampling edge of the wrt plus WDOG_CYC further edges, seen on the next falling edge.
    check_val("wdog_latency", wd, WD + 1);

    mid_frame("trip_a");
    check_val("wdog_held", wdog_trip, 1);
    q_main.push_back(mk(100, 100, 100, 100));
    mid_frame("trip_b");
    check_val("wdog_held2", wdog_trip, 1);
    drive_wrt(50, 50, 50, 50, 1'b0);
    check_val("wdog_clear", wdog_trip, 0);
    q_main.push_back(mk(200, 200, 200, 200));

    wait_frm("end_a");
    wait_frm("end_b");
    repeat (100) @(negedge clk);
    check_val("pwm_midframe", pwm, 4'hF);
    #2 rst_n = 1'b0;
    #1;
    check_val("pwm_async_rst", pwm, 0);
    check_val("pwm_slew_async_rst", pwm_s, 0);
    check_val("wdog_async_rst", wdog_trip, 0);
    check_val("sb_main_drained", q_main.size(), 0);
    check_val("sb_slew_drained", q_slew.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
